// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: one shared prescaler and frame counter driving CHANNELS servo
// PWM lanes. Each lane holds a target width and a current width; the current
// width moves toward the target only at frame wrap, so pulses are never cut short
// or doubled by a write.

// One servo output: target/current registers, frame-rate slew, registered compare.
module servo_pwm_lane #(
    parameter int TICK_W = 12
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wr,          // write strobe for this lane
    input  logic [TICK_W-1:0] wr_data,     // already clamped to FRAME_TICKS
    input  logic [TICK_W-1:0] step,
    input  logic              frame_wrap,
    input  logic [TICK_W-1:0] tick_cnt,
    output logic              pwm
);
    logic [TICK_W-1:0] target;
    logic [TICK_W-1:0] cur;
    logic [TICK_W-1:0] cur_nxt;
    logic [TICK_W:0]   diff;
    logic              up;

    // Slew-limited next width. The distance is taken one bit wider so it
    // cannot wrap. The +/- step branches only run when the distance exceeds
    // step, so they stay inside the range between cur and target.
    always_comb begin
        up      = target > cur;
        diff    = up ? ({1'b0, target} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, target});
        cur_nxt = target;
        if (step != '0 && diff > {1'b0, step})
            cur_nxt = up ? (cur + step) : (cur - step);
    end

    // Target takes writes at any time. Cur changes only at frame wrap, and it
    // reads the target value from before any write on that same edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            target <= '0;
            cur    <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr)         target <= wr_data;
            if (frame_wrap) cur    <= cur_nxt;
            pwm <= tick_cnt < cur;
        end
    end
endmodule

module servo_pwm_bank #(
    parameter int CHANNELS    = 4,
    parameter int PRESCALE_W  = 16,
    parameter int TICK_W      = 12,
    parameter int FRAME_TICKS = 4000,
    parameter int CH_W        = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [PRESCALE_W-1:0] Periodo,
    input  logic [TICK_W-1:0]     Step,
    input  logic                  Wr,
    input  logic [CH_W-1:0]       WrCh,
    input  logic [TICK_W-1:0]     WrData,
    output logic [CHANNELS-1:0]   Out,
    output logic                  FrameStart
);
    localparam logic [TICK_W-1:0] FT   = TICK_W'(FRAME_TICKS);
    localparam logic [TICK_W-1:0] LAST = TICK_W'(FRAME_TICKS - 1);

    typedef struct packed {
        logic              vld;
        logic [CH_W-1:0]   ch;
        logic [TICK_W-1:0] data;
    } wr_req_t;

    logic [PRESCALE_W-1:0] base_cnt;
    logic [TICK_W-1:0]     tick_cnt;
    logic                  tick;
    logic                  frame_wrap;
    wr_req_t               wr_req;

    // Use ">=" instead of "==" so that a Periodo lowered below the running
    // count still produces a tick on the next clock.
    assign tick       = base_cnt >= Periodo;
    assign frame_wrap = tick && (tick_cnt == LAST);
    assign wr_req     = '{vld: Wr, ch: WrCh, data: (WrData > FT) ? FT : WrData};

    // Prescaler: one tick every Periodo+1 clocks.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     base_cnt <= '0;
        else if (tick) base_cnt <= '0;
        else           base_cnt <= base_cnt + 1'b1;
    end

    // Tick counter within the frame. FrameStart is high on the same edge that
    // tick_cnt wraps.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tick_cnt   <= '0;
            FrameStart <= 1'b0;
        end else begin
            FrameStart <= frame_wrap;
            if (frame_wrap) tick_cnt <= '0;
            else if (tick)  tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Lanes decode their own index. A WrCh with no matching lane writes nothing.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        servo_pwm_lane #(.TICK_W(TICK_W)) u_lane (
            .Clock      (Clock),
            .Reset      (Reset),
            .wr         (wr_req.vld && (wr_req.ch == CH_W'(i))),
            .wr_data    (wr_req.data),
            .step       (Step),
            .frame_wrap (frame_wrap),
            .tick_cnt   (tick_cnt),
            .pwm        (Out[i])
        );
    end
endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Parametrised multi-channel servo PWM generator with glitch-free duty updates and per-channel slew limiting. One shared prescaler and frame counter drive CHANNELS independent pulse outputs; software writes target pulse widths through a single-word write port, and each channel's active width ramps toward its target once per frame. Sits between the bus-side register bank and the servo output pins, replacing the single-channel servo driver.

## Interface

- CHANNELS, 4: number of servo outputs (1..16).
- PRESCALE_W, 16: width of prescaler divisor.
- TICK_W, 12: width of tick counter, target and current width registers.
- FRAME_TICKS, 4000: ticks per frame (2..2^TICK_W-1).
- CH_W, 2: width of channel index; must satisfy 2^CH_W >= CHANNELS.

- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Periodo  in  PRESCALE_W  prescaler divisor; one tick every Periodo+1 clocks.
- Step  in  TICK_W  max change of current width per frame; 0 = jump directly to target.
- Wr  in  1  write strobe, one clock.
- WrCh  in  CH_W  channel index for write.
- WrData  in  TICK_W  new target width in ticks.
- Out  out  CHANNELS  registered PWM outputs, bit i = channel i.
- FrameStart  out  1  one-clock pulse at each frame wrap.

## Operation

- Prescaler BaseCounter (PRESCALE_W): increments each clock; when BaseCounter >= Periodo, asserts internal tick and reloads 0. ">=" guarantees recovery when Periodo is lowered below the current count.
- Tick counter TickCnt (TICK_W): on tick, increments; at FRAME_TICKS-1 with tick, wraps to 0 and pulses FrameStart on the same edge.
- Per channel: Target[i] and Cur[i], both TICK_W, reset 0.
- Write: Wr=1 with WrCh < CHANNELS loads Target[WrCh] <= min(WrData, FRAME_TICKS). WrCh >= CHANNELS: ignored, no state change.
- Frame-boundary update, on the edge where TickCnt wraps to 0, for every channel:
  - Step=0 or |Target-Cur| <= Step: Cur <= Target.
  - Target > Cur + Step: Cur <= Cur + Step; Target < Cur - Step: Cur <= Cur - Step. Arithmetic in TICK_W+1 bits; no wrap.
  - Write and frame update on the same edge: update uses the pre-write Target; new Target acts at the following frame.
- Output: every clock Out[i] <= (TickCnt < Cur[i]). Cur=0 -> constantly low; Cur=FRAME_TICKS -> constantly high.
- Cur never changes mid-frame: no truncated or doubled pulses on Target writes.

## Timing

- Reset values: BaseCounter=0, TickCnt=0, Target=0, Cur=0, Out=0, FrameStart=0. Reset mid-frame forces all immediately; first frame after release starts at TickCnt=0.
- Tick period: Periodo+1 clocks. Frame period: FRAME_TICKS*(Periodo+1) clocks.
- Out lags TickCnt/Cur by one clock (registered compare).
- Pulse width on Out[i]: Cur[i]*(Periodo+1) clocks per frame.
- Write-to-effect latency: next frame start after the write edge (or the one after, if coincident); full ramp takes ceil(|Target-Cur|/Step) frames.
- Step and Periodo are sampled live; changes apply from the next frame update / next prescaler compare respectively.

## Test plan

- Reset then CHANNELS=4, FRAME_TICKS=20, Periodo=1, Step=0, write ch0=5 -> after next FrameStart, Out[0] high 10 clocks per 40-clock frame; other bits stay 0; FrameStart every 40 clocks.
- Step=2, ch1 target 0->9 -> Cur[1] per frame 2,4,6,8,9; then write 1 -> 7,5,3,1.
- Write ch2=25 (> FRAME_TICKS) -> clamped to 20, Out[2] constant high; write 0 -> Out[2] constant low after next frame.
- Write on the exact FrameStart edge -> old target applied that frame, new target one frame later; write to WrCh=3 with CHANNELS=3 -> no change anywhere.
- Periodo changed from 100 to 3 while BaseCounter=50 -> tick on next clock, then every 4 clocks; no lock-up.
- Assert Reset mid-pulse -> Out and FrameStart go 0 asynchronously, before the next Clock edge; after release, all channels low until new writes take effect.
